// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline sequencing controller:
//                register/data widths of the five-stage CPU and the
//                controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Register-address and data widths of the CPU datapath.
    localparam int unsigned C_ASIZE = 5;
    localparam int unsigned C_DSIZE = 32;

    // Controller states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,   // normal flow
        MWAIT   = 2'd1,   // data-memory wait
        LUSTALL = 2'd2,   // one-cycle load-use bubble
        FLUSH   = 2'd3    // redirect cleanup
    } state_t;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_hazard_cmp
//  Description : Register-match comparator. Flags a RAW dependency of the
//                ID instruction on the EX producer (o_exhaz) and on the MEM
//                producer (o_memhaz). Register 0 never matches and a source
//                only matches when the ID instruction actually reads it.
//  Ports       : i_rs1/i_rs2, i_use_rs1/i_use_rs2  - ID sources
//                i_ex_waddr/i_ex_wen                - EX destination
//                i_mem_waddr/i_mem_wen              - MEM destination
//                o_exhaz/o_memhaz                   - hazard flags
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl_hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ASIZE = C_ASIZE
) (
    input  logic [ASIZE-1:0] i_rs1,
    input  logic [ASIZE-1:0] i_rs2,
    input  logic             i_use_rs1,
    input  logic             i_use_rs2,
    input  logic [ASIZE-1:0] i_ex_waddr,
    input  logic             i_ex_wen,
    input  logic [ASIZE-1:0] i_mem_waddr,
    input  logic             i_mem_wen,
    output logic             o_exhaz,
    output logic             o_memhaz
);

    logic w_rs1_live;
    logic w_rs2_live;

    // A source takes part in matching only if it is read and is not x0.
    assign w_rs1_live = i_use_rs1 && (i_rs1 != '0);
    assign w_rs2_live = i_use_rs2 && (i_rs2 != '0);

    assign o_exhaz  = i_ex_wen &&
                      ((w_rs1_live && (i_rs1 == i_ex_waddr)) ||
                       (w_rs2_live && (i_rs2 == i_ex_waddr)));

    assign o_memhaz = i_mem_wen &&
                      ((w_rs1_live && (i_rs1 == i_mem_waddr)) ||
                       (w_rs2_live && (i_rs2 == i_mem_waddr)));

endmodule : pipe_hazard_ctrl_hazard_cmp
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline sequencing controller for the five-stage CPU.
//                Produces hold/bubble/flush controls for PC, IF/ID, ID/EX
//                and EX/MEM, freezes the pipe on data-memory wait, resolves
//                EX redirects and keeps saturating stall/flush counters.
//  Config      : FWD_PATH_EN - defined: forwarding exists, only load-use
//                stalls (one cycle via LUSTALL). Undefined: every EX/MEM
//                RAW hazard stalls until the producer reaches writeback.
//  Ports       : clk, rst (sync, active high)
//                id_*        - ID sources and use bits
//                ex_*, mem_* - producer info, redirect, memory handshake
//                pc_write, ifid_write, ifid_flush, idex_write,
//                idex_bubble, exmem_write - pipeline controls
//                stall_cnt, flush_cnt     - statistics counters
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ASIZE = C_ASIZE,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs1,
    input  logic [ASIZE-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_wen,
    input  logic             ex_memRead,
    input  logic             ex_redirect,
    input  logic [ASIZE-1:0] mem_waddr,
    input  logic             mem_wen,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_exhaz;
    logic             w_memhaz;
    logic             w_freeze;
    logic             w_stall_req;
    logic             w_flush_inc;

    pipe_hazard_ctrl_hazard_cmp #(
        .ASIZE (ASIZE)
    ) u_hazard_cmp (
        .i_rs1       (id_rs1),
        .i_rs2       (id_rs2),
        .i_use_rs1   (id_use_rs1),
        .i_use_rs2   (id_use_rs2),
        .i_ex_waddr  (ex_waddr),
        .i_ex_wen    (ex_wen),
        .i_mem_waddr (mem_waddr),
        .i_mem_wen   (mem_wen),
        .o_exhaz     (w_exhaz),
        .o_memhaz    (w_memhaz)
    );

    // Waiting memory holds the whole pipe; MWAIT is left as soon as the
    // freeze condition clears and that cycle is evaluated like RUN.
    assign w_freeze = mem_req && !mem_ready;

`ifdef FWD_PATH_EN
    // Forwarding covers ALU results; only a load feeding ID must wait.
    localparam state_t C_STALL_STATE = LUSTALL;
    assign w_stall_req = ex_memRead && w_exhaz;
`else
    // No forwarding: hold ID until the producer leaves MEM. The load-use
    // case is a subset and needs no separate state.
    localparam state_t C_STALL_STATE = RUN;
    assign w_stall_req = (ex_memRead && w_exhaz) || w_exhaz || w_memhaz;
`endif

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exmem_write = 1'b1;
        w_state_nxt = RUN;
        w_flush_inc = 1'b0;

        if (rst) begin
            // Reset loads a bubble into ID/EX so no stale control escapes.
            idex_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            w_state_nxt = MWAIT;
        end else if (ex_redirect) begin
            // The wrong-path ID instruction is discarded, so any hazard it
            // carries is irrelevant: flush only, no stall.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_flush_inc = 1'b1;
            w_state_nxt = FLUSH;
        end else if (((r_state == RUN) || (r_state == MWAIT)) && w_stall_req) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            w_state_nxt = C_STALL_STATE;
        end
        // LUSTALL and FLUSH are one cycle of normal flow back to RUN.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed bench for pipe_hazard_ctrl. Two instances share
//                stimulus: a 16-bit counter build and a 2-bit counter build
//                whose counters reach saturation quickly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // Control vector order: {pc_write, ifid_write, ifid_flush,
    //                        idex_write, idex_bubble, exmem_write}
    localparam logic [5:0] C_NORM  = 6'b110101;
    localparam logic [5:0] C_RST   = 6'b110111;
    localparam logic [5:0] C_STALL = 6'b000111;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_RDIR  = 6'b111111;
`ifdef FWD_PATH_EN
    localparam logic [5:0] C_DHAZ  = C_NORM;   // forwarded, no stall
`else
    localparam logic [5:0] C_DHAZ  = C_STALL;  // waits for writeback
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_waddr, mem_waddr;
    logic       id_use_rs1, id_use_rs2, ex_wen, ex_memRead, ex_redirect;
    logic       mem_wen, mem_req, mem_ready;

    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_bubble, s_exmem_write;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference counter values (16-bit and 2-bit builds).
    int m_stall = 0, m_flush = 0, ms_stall = 0, ms_flush = 0;

    typedef struct {
        logic [5:0] ctrl;
        int         stall;
        int         flush;
        int         sstall;
        int         sflush;
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ASIZE(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_memRead(ex_memRead), .ex_redirect(ex_redirect),
        .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.ASIZE(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_memRead(ex_memRead), .ex_redirect(ex_redirect),
        .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_write(s_idex_write), .idex_bubble(s_idex_bubble), .exmem_write(s_exmem_write),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_waddr = 5'd0; ex_wen = 1'b0; ex_memRead = 1'b0; ex_redirect = 1'b0;
        mem_waddr = 5'd0; mem_wen = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // One clock cycle with the currently driven inputs: push the expected
    // outputs (counters reflect all earlier cycles), advance the reference
    // counters, then pop and compare on the falling edge.
    task automatic cycle(input logic [5:0] exp_ctrl, input string tag);
        exp_t e;
        exp_t got;
        e.ctrl = exp_ctrl; e.stall = m_stall; e.flush = m_flush;
        e.sstall = ms_stall; e.sflush = ms_flush; e.tag = tag;
        sb.push_back(e);
        if (rst) begin
            m_stall = 0; m_flush = 0; ms_stall = 0; ms_flush = 0;
        end else begin
            if (!exp_ctrl[5]) begin
                m_stall  = sat_inc(m_stall, 65535);
                ms_stall = sat_inc(ms_stall, 3);
            end
            if (exp_ctrl[3]) begin
                m_flush  = sat_inc(m_flush, 65535);
                ms_flush = sat_inc(ms_flush, 3);
            end
        end
        @(negedge clk);
        got = sb.pop_front();
        check_val({got.tag, ".ctrl"}, 32'({pc_write, ifid_write, ifid_flush,
                  idex_write, idex_bubble, exmem_write}), 32'(got.ctrl));
        check_val({got.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(got.stall));
        check_val({got.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(got.flush));
        check_val({got.tag, ".s_stall_cnt"}, 32'(s_stall_cnt), 32'(got.sstall));
        check_val({got.tag, ".s_flush_cnt"}, 32'(s_flush_cnt), 32'(got.sflush));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        // Reset overrides redirect, then also a pending memory freeze.
        rst = 1'b1; ex_redirect = 1'b1;
        cycle(C_RST, "reset0");
        mem_req = 1'b1;
        cycle(C_RST, "reset1");
        rst = 1'b0; clear_inputs();
        cycle(C_NORM, "idle");

        // Redirect together with a load-use: flush only.
        ex_redirect = 1'b1; ex_memRead = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd3;
        id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        cycle(C_RDIR, "redir_lu");
        clear_inputs();
        cycle(C_NORM, "flush_cyc");
        cycle(C_NORM, "post_flush");

        // Load-use on rs1; the load then advances to MEM.
        ex_memRead = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        cycle(C_STALL, "lu_stall");
        ex_memRead = 1'b0; ex_wen = 1'b0; ex_waddr = 5'd0; mem_wen = 1'b1; mem_waddr = 5'd3;
        cycle(C_DHAZ, "lu_mem");
        clear_inputs();
        cycle(C_NORM, "lu_done");

        // x0 never matches; an unused source never matches.
        ex_memRead = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cycle(C_NORM, "lu_x0");
        ex_waddr = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b0;
        cycle(C_NORM, "lu_nouse");
        clear_inputs();

        // Three cycles of memory wait, then release.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle(C_FRZ, "mwait");
        mem_ready = 1'b1;
        cycle(C_NORM, "mw_release");
        // Release cycle re-evaluates: a redirect there is taken.
        mem_ready = 1'b0;
        cycle(C_FRZ, "mwait2");
        mem_ready = 1'b1; ex_redirect = 1'b1;
        cycle(C_RDIR, "mw_redir");
        clear_inputs();
        cycle(C_NORM, "mw_flush_cyc");

        // ALU producer on rs2: in EX then in MEM.
        ex_wen = 1'b1; ex_waddr = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cycle(C_DHAZ, "alu_ex");
        ex_wen = 1'b0; ex_waddr = 5'd0; mem_wen = 1'b1; mem_waddr = 5'd5;
        cycle(C_DHAZ, "alu_mem");
        clear_inputs();
        cycle(C_NORM, "alu_done");

        // Freeze outranks redirect; redirect is taken when memory completes.
        mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
        cycle(C_FRZ, "frz_redir");
        mem_ready = 1'b1;
        cycle(C_RDIR, "frz_redir_rel");
        clear_inputs();
        cycle(C_NORM, "frz_redir_done");

        // Reset in the middle of a memory wait abandons it.
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle(C_FRZ, "pre_rst_wait");
        rst = 1'b1;
        cycle(C_RST, "mid_rst");
        rst = 1'b0; clear_inputs();
        cycle(C_NORM, "after_rst");

        // Saturation of the 2-bit counters (and continued counting at 16).
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle(C_FRZ, "sat_stall");
        clear_inputs();
        ex_redirect = 1'b1;
        for (int i = 0; i < 5; i++) cycle(C_RDIR, "sat_flush");
        clear_inputs();
        cycle(C_NORM, "sat_check");
        cycle(C_NORM, "sat_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
